fdiv: RTL
=========

FDIV -- requirements
Module: fdiv

Interface
REQ-001 DIN_WIDTH, 16, total width of dividend and divisor.
REQ-002 DIN_FRAC, 15, fractional bits of dividend and divisor.
REQ-003 DOUT_WIDTH, 16, total width of quotient.
REQ-004 DOUT_FRAC, 15, fractional bits of quotient.
REQ-005 i_clk  in  1  the only clock; all state changes on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-007 i_dividend  in  DIN_WIDTH  signed fixed-point dividend.
REQ-008 i_divisor  in  DIN_WIDTH  signed fixed-point divisor.
REQ-009 i_ovr  in  1  upstream overflow flag, sampled with the operands.
REQ-010 i_valid  in  1  operands valid.
REQ-011 o_ready  out  1  divider can accept operands.
REQ-012 o_quotient  out  DOUT_WIDTH  signed fixed-point quotient.
REQ-013 o_ovr  out  1  quotient overflow, divide-by-zero or propagated i_ovr.
REQ-014 o_valid  out  1  o_quotient/o_ovr valid.
REQ-015 i_ready  in  1  downstream accepts result.

Function
REQ-016 FSM states IDLE, CALC, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-017 Operands, i_ovr, and the result sign are captured on the edge where i_valid&&o_ready; state IDLE->CALC.
REQ-018 Magnitudes are formed at DIN_WIDTH+1 bits so that |-2^(DIN_WIDTH-1)| is exact.
REQ-019 Unsigned restoring division, one quotient bit per cycle: numerator = |dividend|<<DOUT_FRAC, QW = DIN_WIDTH+DOUT_FRAC bits, QW CALC iterations.
REQ-020 After the last iteration, one finalize cycle applies sign, saturation and flag merge, then the state goes to DONE.
REQ-021 Latency is exactly QW+1 cycles from the accept edge to o_valid high (32 at default parameters).
REQ-022 Quotient truncates toward zero; no rounding.
REQ-023 Positive result above 2^(DOUT_WIDTH-1)-1 saturates to max positive and sets overflow.
REQ-024 Negative result with magnitude above 2^(DOUT_WIDTH-1) saturates to min negative and sets overflow; exactly -2^(DOUT_WIDTH-1) is not overflow.
REQ-025 Divisor zero skips the iterations (latency unchanged) and sets overflow.
REQ-026 Divisor zero gives max positive for dividend>=0 and min negative for dividend<0.
REQ-027 o_ovr = captured i_ovr | saturation | divide-by-zero.
REQ-028 In DONE, o_quotient/o_ovr hold stable until i_valid is irrelevant and i_ready=1; state DONE->IDLE on that edge.
REQ-029 i_valid outside IDLE is ignored; no operand is queued; the divider does not accept in the same cycle it leaves DONE.
REQ-030 Zero dividend with non-zero divisor gives 0, no overflow.

Reset
REQ-031 Asserted i_rst_n forces IDLE immediately, including mid-CALC or DONE; any in-flight result is discarded.
REQ-032 Reset values: o_quotient=0, o_ovr=0, o_valid=0, o_ready=1 after release; iteration counter and remainder = 0.

Structure
REQ-033 The FSM state enum and iteration-count width function belong in the shared package fixed_point_pkg.
REQ-034 A single sub-module fdiv_core holds the unsigned restoring iterator (remainder, partial quotient, counter); fdiv holds the handshake, sign and saturation logic.

Verification
REQ-035 0x2000 / 0x4000 -> o_quotient 0x4000, o_ovr 0, o_valid exactly 32 cycles after accept.
REQ-036 0xE000 / 0x4000 -> 0xC000, o_ovr 0; 0xC000 / 0x4000 -> 0x8000, o_ovr 0.
REQ-037 0x4000 / 0x2000 -> 0x7FFF, o_ovr 1; 0xC000 / 0x2000 -> 0x8000, o_ovr 1.
REQ-038 0x1000 / 0x0000 -> 0x7FFF, o_ovr 1; 0xF000 / 0x0000 -> 0x8000, o_ovr 1; 0x0001 / 0x0003 -> 0x2AAA (truncation).
REQ-039 i_ovr=1 with 0x2000 / 0x4000 -> 0x4000, o_ovr 1; i_ready held 0 for 10 cycles -> result stable and o_ready 0 throughout.
REQ-040 i_rst_n pulsed low mid-CALC -> o_valid 0, o_ready 1 after release; the next operation 0x2000 / 0x4000 completes correctly with 0x4000.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point divider: FSM state encoding and
// the width helper used to size iteration counters.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fdiv_state_t;

    // Bits needed for a counter that must reach the value n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fdiv_if.sv
// Operand/result handshake bundle for the fixed-point divider.
// master drives operands and accepts results; slave is the divider.
interface fdiv_if #(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 16
);
    logic [DIN_WIDTH-1:0]  i_dividend;
    logic [DIN_WIDTH-1:0]  i_divisor;
    logic                  i_ovr;
    logic                  i_valid;
    logic                  o_ready;
    logic [DOUT_WIDTH-1:0] o_quotient;
    logic                  o_ovr;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_dividend, i_divisor, i_ovr, i_valid, i_ready,
        input  o_ready, o_quotient, o_ovr, o_valid
    );

    modport slave (
        input  i_dividend, i_divisor, i_ovr, i_valid, i_ready,
        output o_ready, o_quotient, o_ovr, o_valid
    );
endinterface

// File: rtl/fdiv_core.sv
// Unsigned restoring divider: one quotient bit per enabled cycle, NW cycles
// after a load. A skipped (divide-by-zero) load only counts, leaving quot 0.
module fdiv_core
    import fixed_point_pkg::*;
#(
    parameter int NW = 31,
    parameter int DW = 17
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_run,
    input  logic          i_skip,
    input  logic [NW-1:0] i_num,
    input  logic [DW-1:0] i_den,
    output logic [NW-1:0] o_quot,
    output logic          o_done
);
    localparam int CW = cnt_width(NW);

    logic [NW-1:0] r_num;
    logic [NW-1:0] r_quot;
    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_den;
    logic [CW-1:0] r_cnt;
    logic          r_skip;

    logic [DW:0]   w_shift;
    logic [DW:0]   w_diff;
    logic          w_ge;
    logic          w_done;

    // Remainder stays below the divisor, so the borrow bit of the trial
    // subtraction is a reliable "fits" indicator.
    assign w_shift = {r_rem, r_num[NW-1]};
    assign w_diff  = w_shift - {1'b0, r_den};
    assign w_ge    = ~w_diff[DW];
    assign w_done  = (r_cnt == CW'(NW));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_skip <= 1'b0;
        end else if (i_load) begin
            r_num  <= i_num;
            r_quot <= '0;
            r_rem  <= '0;
            r_den  <= i_den;
            r_cnt  <= '0;
            r_skip <= i_skip;
        end else if (i_run && !w_done) begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_skip) begin
                r_num  <= {r_num[NW-2:0], 1'b0};
                r_rem  <= w_ge ? w_diff[DW-1:0] : w_shift[DW-1:0];
                r_quot <= {r_quot[NW-2:0], w_ge};
            end
        end
    end

    assign o_quot = r_quot;
    assign o_done = w_done;
endmodule

// File: rtl/fdiv.sv
// Signed fixed-point divider: handshake FSM, sign/magnitude conversion,
// saturation and overflow merge around the unsigned fdiv_core iterator.
module fdiv
    import fixed_point_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_FRAC   = 15,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_FRAC  = 15
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    fdiv_if.slave bus
);
    // Both operands carry DIN_FRAC bits, which cancel in the quotient.
    localparam int NUM_SHIFT = DOUT_FRAC + DIN_FRAC - DIN_FRAC;
    localparam int QW        = DIN_WIDTH + DOUT_FRAC;
    localparam logic [DOUT_WIDTH-1:0] MAX_POS = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] MIN_NEG = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    fdiv_state_t r_state, w_state_next;

    logic                  r_res_neg;
    logic                  r_dvd_neg;
    logic                  r_dz;
    logic                  r_ovr_in;
    logic [DOUT_WIDTH-1:0] r_quotient;
    logic                  r_ovr;

    logic                  w_accept;
    logic                  w_finalize;
    logic [DIN_WIDTH:0]    w_dvd_mag;
    logic [DIN_WIDTH:0]    w_dvs_mag;
    logic [QW-1:0]         w_num;
    logic [QW-1:0]         w_core_quot;
    logic                  w_core_done;
    logic [DOUT_WIDTH-1:0] w_fin_q;
    logic                  w_fin_sat;

    assign w_accept   = (r_state == ST_IDLE) && bus.i_valid;
    assign w_finalize = (r_state == ST_CALC) && w_core_done;

    // One extra bit so the magnitude of the most negative operand is exact.
    assign w_dvd_mag = bus.i_dividend[DIN_WIDTH-1]
                     ? -{1'b1, bus.i_dividend} : {1'b0, bus.i_dividend};
    assign w_dvs_mag = bus.i_divisor[DIN_WIDTH-1]
                     ? -{1'b1, bus.i_divisor} : {1'b0, bus.i_divisor};
    assign w_num     = QW'({w_dvd_mag, {NUM_SHIFT{1'b0}}});

    fdiv_core #(
        .NW (QW),
        .DW (DIN_WIDTH + 1)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept),
        .i_run   (r_state == ST_CALC),
        .i_skip  (bus.i_divisor == '0),
        .i_num   (w_num),
        .i_den   (w_dvs_mag),
        .o_quot  (w_core_quot),
        .o_done  (w_core_done)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_valid) w_state_next = ST_CALC;
            ST_CALC: if (w_core_done) w_state_next = ST_DONE;
            ST_DONE: if (bus.i_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Magnitude quotient truncates, so applying the sign truncates toward zero.
    always_comb begin
        w_fin_q   = '0;
        w_fin_sat = 1'b0;
        if (r_dz) begin
            w_fin_sat = 1'b1;
            w_fin_q   = r_dvd_neg ? MIN_NEG : MAX_POS;
        end else if (!r_res_neg) begin
            if (w_core_quot > QW'(MAX_POS)) begin
                w_fin_sat = 1'b1;
                w_fin_q   = MAX_POS;
            end else begin
                w_fin_q = w_core_quot[DOUT_WIDTH-1:0];
            end
        end else begin
            if (w_core_quot > QW'(MIN_NEG)) begin
                w_fin_sat = 1'b1;
                w_fin_q   = MIN_NEG;
            end else begin
                w_fin_q = -w_core_quot[DOUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_res_neg  <= 1'b0;
            r_dvd_neg  <= 1'b0;
            r_dz       <= 1'b0;
            r_ovr_in   <= 1'b0;
            r_quotient <= '0;
            r_ovr      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_res_neg <= bus.i_dividend[DIN_WIDTH-1] ^ bus.i_divisor[DIN_WIDTH-1];
                r_dvd_neg <= bus.i_dividend[DIN_WIDTH-1];
                r_dz      <= (bus.i_divisor == '0);
                r_ovr_in  <= bus.i_ovr;
            end
            if (w_finalize) begin
                r_quotient <= w_fin_q;
                r_ovr      <= r_ovr_in | w_fin_sat;
            end
        end
    end

    assign bus.o_ready    = (r_state == ST_IDLE);
    assign bus.o_valid    = (r_state == ST_DONE);
    assign bus.o_quotient = r_quotient;
    assign bus.o_ovr      = r_ovr;
endmodule
